// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction fetch stage.
//   - NOP encoding and reset-PC defaults
//   - RISC-V base opcode constants (decoded downstream from opcode)
//   - FSM state encoding for instr_fetch
package instr_fetch_pkg;

   localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;  // addi x0,x0,0
   localparam logic [63:0] RESET_PC_DEFAULT  = 64'h0;
   localparam logic [63:0] PC_ALIGN_MASK     = ~64'h3;

   localparam logic [6:0] OPC_LOAD     = 7'b000_0011;
   localparam logic [6:0] OPC_MISC_MEM = 7'b000_1111;
   localparam logic [6:0] OPC_OP_IMM   = 7'b001_0011;
   localparam logic [6:0] OPC_AUIPC    = 7'b001_0111;
   localparam logic [6:0] OPC_OP_IMM32 = 7'b001_1011;
   localparam logic [6:0] OPC_STORE    = 7'b010_0011;
   localparam logic [6:0] OPC_OP       = 7'b011_0011;
   localparam logic [6:0] OPC_LUI      = 7'b011_0111;
   localparam logic [6:0] OPC_OP32     = 7'b011_1011;
   localparam logic [6:0] OPC_BRANCH   = 7'b110_0011;
   localparam logic [6:0] OPC_JALR     = 7'b110_0111;
   localparam logic [6:0] OPC_JAL      = 7'b110_1111;
   localparam logic [6:0] OPC_SYSTEM   = 7'b111_0011;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_REQ   = 3'd1,
      S_WAIT  = 3'd2,
      S_HOLD  = 3'd3,
      S_DRAIN = 3'd4
   } fetch_state_t;

endpackage

// File: rtl/instr_fetch_pc_reg.sv
// pc_reg: 64-bit register with load-enable and asynchronous active-high reset.
// Ports:
//   clk  - clock
//   arst - asynchronous reset, loads RESET_VAL
//   load - capture d on the rising edge
//   d    - next value
//   q    - current value
module pc_reg #(
   parameter logic [63:0] RESET_VAL = 64'h0
) (
   input  logic        clk,
   input  logic        arst,
   input  logic        load,
   input  logic [63:0] d,
   output logic [63:0] q
);

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         q <= RESET_VAL;
      end else if (load) begin
         q <= d;
      end
   end

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: IF stage with a single outstanding instruction-memory request
// and an IF/ID output register.
// Ports:
//   clk, arst               - clock, asynchronous active-high reset
//   stall                   - hold the IF/ID output register
//   redirect, redirect_pc   - flush and refetch from redirect_pc (word aligned)
//   imem_req, imem_addr     - one-cycle read request to instruction memory
//   imem_rvalid, imem_rdata - read response
//   instr_valid, instr,
//   instr_pc                - IF/ID register contents
//   opcode                  - instr[6:0]
module instr_fetch
   import instr_fetch_pkg::*;
#(
   parameter logic [63:0] RESET_PC  = RESET_PC_DEFAULT,
   parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
   input  logic        clk,
   input  logic        arst,
   input  logic        stall,
   input  logic        redirect,
   input  logic [63:0] redirect_pc,
   output logic        imem_req,
   output logic [63:0] imem_addr,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic        instr_valid,
   output logic [31:0] instr,
   output logic [63:0] instr_pc,
   output logic [6:0]  opcode
);

   fetch_state_t state, state_next;

   logic [63:0] pc;
   logic [63:0] pc_d;
   logic        pc_load;
   logic [31:0] hold_instr, hold_d;
   logic [31:0] instr_d;
   logic [63:0] instr_pc_d;
   logic        instr_valid_d;

   pc_reg #(.RESET_VAL(RESET_PC)) u_pc_reg (
      .clk  (clk),
      .arst (arst),
      .load (pc_load),
      .d    (pc_d),
      .q    (pc)
   );

   // Request is a pure decode of the state so reset clears it without a clock.
   assign imem_req  = (state == S_REQ);
   assign imem_addr = imem_req ? (pc & PC_ALIGN_MASK) : 64'h0;
   assign opcode    = instr[6:0];

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         state       <= S_IDLE;
         instr       <= NOP_INSTR;
         instr_pc    <= 64'h0;
         instr_valid <= 1'b0;
         hold_instr  <= 32'h0;
      end else begin
         state       <= state_next;
         instr       <= instr_d;
         instr_pc    <= instr_pc_d;
         instr_valid <= instr_valid_d;
         hold_instr  <= hold_d;
      end
   end

   always_comb begin
      state_next    = state;
      pc_load       = 1'b0;
      pc_d          = pc + 64'd4;   // wraps modulo 2^64
      instr_d       = instr;
      instr_pc_d    = instr_pc;
      instr_valid_d = instr_valid;
      hold_d        = hold_instr;

      if (redirect) begin
         pc_load       = 1'b1;
         pc_d          = redirect_pc & PC_ALIGN_MASK;
         instr_d       = NOP_INSTR;
         instr_valid_d = 1'b0;
         hold_d        = 32'h0;
         // A request still in flight must be drained before refetching,
         // otherwise its response would be mistaken for the new target's.
         case (state)
            S_REQ:   state_next = S_DRAIN;
            S_WAIT:  state_next = imem_rvalid ? S_REQ : S_DRAIN;
            S_DRAIN: state_next = imem_rvalid ? S_REQ : S_DRAIN;
            default: state_next = S_REQ;
         endcase
      end else begin
         // Bubble whenever nothing loads and the stage is not stalled.
         if (!stall) begin
            instr_d       = NOP_INSTR;
            instr_valid_d = 1'b0;
         end
         case (state)
            S_IDLE: state_next = S_REQ;
            S_REQ:  state_next = S_WAIT;
            S_WAIT: begin
               if (imem_rvalid) begin
                  if (!stall) begin
                     instr_d       = imem_rdata;
                     instr_pc_d    = pc;
                     instr_valid_d = 1'b1;
                     pc_load       = 1'b1;
                     state_next    = S_REQ;
                  end else begin
                     hold_d     = imem_rdata;
                     state_next = S_HOLD;
                  end
               end
            end
            S_HOLD: begin
               if (!stall) begin
                  instr_d       = hold_instr;
                  instr_pc_d    = pc;
                  instr_valid_d = 1'b1;
                  pc_load       = 1'b1;
                  state_next    = S_REQ;
               end
            end
            S_DRAIN: begin
               // Stall has no meaning here: the register already holds a bubble.
               instr_d       = NOP_INSTR;
               instr_valid_d = 1'b0;
               if (imem_rvalid) begin
                  state_next = S_REQ;
               end
            end
            default: state_next = S_IDLE;
         endcase
      end
   end

endmodule
